// File: rtl/hazard_controller.sv
// hazard_controller
//   Hazard and sequencing controller for the 5-stage RISC-V pipeline.
//   Selects execute-stage operand forwarding, raises stall/flush for
//   load-use hazards and taken branches, and sequences multi-cycle
//   execute ops (mul/div). While one of these ops runs, F/D/E are held
//   and bubbles are injected into M until the result is ready.
//
//   Ports
//     clk, reset                 rising-edge clock, synchronous active-high reset
//     Rs1D, Rs2D                 decode-stage source registers
//     Rs1E, Rs2E, RdE            execute-stage source/destination registers
//     RdM, RdW                   memory/writeback destination registers
//     RegWriteM, RegWriteW       memory/writeback register-write enables
//     ResultSrcE                 execute result select (2'b01 = load)
//     PCSrcE                     taken branch/jump resolved in execute
//     MultiCycleE                execute holds a multi-cycle op
//     ForwardAE, ForwardBE       00 = regfile, 01 = ResultW, 10 = ALUResultM
//     StallF, StallD, StallE     hold pipeline registers
//     FlushD, FlushE, FlushM     bubble pipeline registers
//     MCStartE                   multi-cycle unit captures operands this cycle
//     MCDoneE                    multi-cycle result valid; EX advances after it
//
//   Multi-cycle sequencer
//     state | meaning
//     IDLE  | no op in flight; a multi-cycle op seen here starts this cycle
//     BUSY  | op running, cnt counts down the remaining held cycles
//     DONE  | last EX cycle of the op, result valid, pipeline released

module hazard_controller #(
   parameter int MC_LATENCY = 4,
   parameter int CNT_W      = $clog2(MC_LATENCY)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic [4:0] Rs1E,
   input  logic [4:0] Rs2E,
   input  logic [4:0] RdE,
   input  logic [4:0] RdM,
   input  logic [4:0] RdW,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic [1:0] ResultSrcE,
   input  logic       PCSrcE,
   input  logic       MultiCycleE,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       FlushD,
   output logic       FlushE,
   output logic       FlushM,
   output logic       MCStartE,
   output logic       MCDoneE
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mc_state_t;

   // Start cycle and DONE cycle bracket the BUSY run, so BUSY lasts
   // MC_LATENCY-2 cycles and the counter is loaded with one less.
   localparam int               CNT_START_I = (MC_LATENCY > 2) ? MC_LATENCY - 3 : 0;
   localparam logic [CNT_W-1:0] CNT_START   = CNT_W'(CNT_START_I);

   mc_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic             lw_stall;
   logic             mc_start;
   logic             mc_stall;

   always_comb begin
      ForwardAE = 2'b00;
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
         ForwardAE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
         ForwardAE = 2'b01;
   end

   always_comb begin
      ForwardBE = 2'b00;
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
         ForwardBE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
         ForwardBE = 2'b01;
   end

   assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));

   // A taken branch in the same cycle squashes the op instead of starting it.
   assign mc_start = (state == IDLE) && MultiCycleE && !PCSrcE;
   assign mc_stall = mc_start || (state == BUSY);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mc_start) begin
                  if (MC_LATENCY == 2) begin
                     state <= DONE;
                  end else begin
                     state <= BUSY;
                     cnt   <= CNT_START;
                  end
               end
            end
            BUSY: begin
               if (cnt == '0)
                  state <= DONE;
               else
                  cnt <= cnt - CNT_W'(1);
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign MCStartE = mc_start;
   assign MCDoneE  = (state == DONE) && !reset;

   assign StallF = lw_stall || mc_stall;
   assign StallD = lw_stall || mc_stall;
   assign StallE = mc_stall;
   assign FlushM = mc_stall;
   // A held multi-cycle op must never be flushed out of D/E.
   assign FlushD = PCSrcE && !mc_stall;
   assign FlushE = (lw_stall || PCSrcE) && !mc_stall;

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller
//   Directed scenarios followed by randomized traffic, every cycle compared
//   against a reference model that tracks how many cycles the current
//   multi-cycle op has spent in EX.

module tb_hazard_controller;

   localparam int L = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic       RegWriteM, RegWriteW;
   logic [1:0] ResultSrcE;
   logic       PCSrcE, MultiCycleE;
   logic [1:0] ForwardAE, ForwardBE;
   logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MCStartE, MCDoneE;

   int n_tests = 0;
   int n_fail  = 0;

   // age: EX cycles already spent by the in-flight op (0 = nothing in flight)
   int age = 0;
   int cur = 0;

   hazard_controller #(.MC_LATENCY(L)) dut (
      .clk(clk), .reset(reset),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE),
      .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
      .MCStartE(MCStartE), .MCDoneE(MCDoneE)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int fwd_exp(input logic [4:0] rs);
      if (RegWriteM && RdM != 0 && RdM == rs) return 2;
      if (RegWriteW && RdW != 0 && RdW == rs) return 1;
      return 0;
   endfunction

   task automatic clear_inputs();
      Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
      RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0; MultiCycleE = 0;
   endtask

   // One pipeline cycle: compare at negedge, advance the model at posedge.
   task automatic step();
      bit lw, start, stall;
      @(negedge clk);
      start = (age == 0) && MultiCycleE && !PCSrcE;
      cur   = (age == 0) ? (start ? 1 : 0) : age;
      stall = (cur >= 1) && (cur <= L - 1);
      lw    = (ResultSrcE == 2'b01) && (RdE != 0) && ((RdE == Rs1D) || (RdE == Rs2D));
      check_val("ForwardAE", int'(ForwardAE), fwd_exp(Rs1E));
      check_val("ForwardBE", int'(ForwardBE), fwd_exp(Rs2E));
      check_val("StallF",    int'(StallF),    int'(lw || stall));
      check_val("StallD",    int'(StallD),    int'(lw || stall));
      check_val("StallE",    int'(StallE),    int'(stall));
      check_val("FlushM",    int'(FlushM),    int'(stall));
      check_val("FlushD",    int'(FlushD),    int'(PCSrcE && !stall));
      check_val("FlushE",    int'(FlushE),    int'((lw || PCSrcE) && !stall));
      check_val("MCStartE",  int'(MCStartE),  int'(start));
      check_val("MCDoneE",   int'(MCDoneE),   int'(cur == L && !reset));
      @(posedge clk);
      if (reset || cur == 0 || cur == L) age = 0;
      else                               age = cur + 1;
      #1;
   endtask

   initial begin
      clear_inputs();
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      age   = 0;
      reset = 1'b0;
      step();                                     // all outputs idle after reset

      // forwarding priority
      Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs2E = 5;
      step();
      RegWriteM = 0;
      step();
      RdM = 0; RdW = 0; Rs1E = 0; RegWriteM = 1;
      step();

      // load-use
      clear_inputs();
      ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
      step();
      RdE = 0;
      step();

      // taken branch with a simultaneous multi-cycle request
      clear_inputs();
      PCSrcE = 1; MultiCycleE = 1;
      step();
      clear_inputs();
      step();

      // single op, then back-to-back ops
      MultiCycleE = 1;
      repeat (L) step();
      MultiCycleE = 0;
      step();
      MultiCycleE = 1;
      repeat (2 * L) step();
      MultiCycleE = 0;
      step();

      // branch and load-use during BUSY must not flush
      MultiCycleE = 1;
      step();
      PCSrcE = 1; ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
      repeat (L - 1) step();
      clear_inputs();
      step();

      // reset in the first BUSY cycle aborts the op, then a fresh full run
      MultiCycleE = 1;
      step();
      reset = 1;
      step();
      reset = 0; MultiCycleE = 0;
      repeat (L) step();
      MultiCycleE = 1;
      repeat (L) step();
      MultiCycleE = 0;
      step();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
         Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
         RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
         RdW  = 5'($urandom_range(0, 3));
         RegWriteM   = 1'($urandom_range(0, 1));
         RegWriteW   = 1'($urandom_range(0, 1));
         ResultSrcE  = 2'($urandom_range(0, 3));
         PCSrcE      = ($urandom_range(0, 7) == 0);
         MultiCycleE = ($urandom_range(0, 3) == 0);
         reset       = ($urandom_range(0, 63) == 0);
         step();
      end
      reset = 0;
      clear_inputs();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
